// File: rtl/uart_frame_seq_tx.sv
// uart_frame_seq_tx: buffers command bytes in a small FIFO and serialises them
// as back-to-back UART frames (start, LSB-first data, optional parity, stop).
// Optional build macro UART_FRAME_GAP_EN inserts GAP_BITS idle-high bit
// periods after the stop bits of every frame.
//
// Write side handshake: wr_en is a one-cycle push request; there is no ready.
// A push is accepted when the FIFO is not full, or when a pop happens in the
// same cycle. A push that is refused sets the sticky overflow flag.
module uart_frame_seq_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int STOP_BITS  = 1,
    parameter int CNT_WIDTH  = 16,
    parameter int GAP_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  bit_tick,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  frame_done,
    output logic [CNT_WIDTH-1:0]  frames_sent
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] BIT_LAST  = 4'(DATA_WIDTH - 1);
    localparam logic [0:0] STOP_LAST = 1'(STOP_BITS - 1);

    // Elaboration-time guard against unsupported configurations
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        STOP_BITS < 1 || STOP_BITS > 2 || GAP_BITS < 1 || CNT_WIDTH < 1) begin : g_cfg_err
        $error("uart_frame_seq_tx: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_FRAME_GAP_EN
        , S_GAP
`endif
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_en_q;
    logic                  par_bit;
    logic [3:0]            bit_cnt;
    logic [0:0]            stop_cnt;
    logic                  stop_last;
    logic                  frame_end;
    logic                  push;
    logic                  pop;

`ifdef UART_FRAME_GAP_EN
    localparam int GW = $clog2(GAP_BITS) + 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);
    logic [GW-1:0] gap_cnt;
`endif

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign stop_last = (stop_cnt == STOP_LAST);

`ifdef UART_FRAME_GAP_EN
    assign frame_end = (state == S_GAP) && (gap_cnt == GAP_LAST);
`else
    assign frame_end = (state == S_STOP) && stop_last;
`endif

    // The head is consumed whenever a new frame begins: from IDLE or at the
    // tick that ends the previous frame.
    assign pop  = bit_tick && !empty && ((state == S_IDLE) || frame_end);
    assign push = wr_en && (!full || pop);

    // FIFO storage; written only on accepted pushes
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (wr_en && !push) overflow <= 1'b1;
        end
    end

    // Frame sequencer: every line change happens on a bit_tick cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            tx_out      <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frames_sent <= '0;
            shift       <= '0;
            par_en_q    <= 1'b0;
            par_bit     <= 1'b0;
            bit_cnt     <= '0;
            stop_cnt    <= '0;
`ifdef UART_FRAME_GAP_EN
            gap_cnt     <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (bit_tick) begin
                if (frame_end) begin
                    frame_done  <= 1'b1;
                    frames_sent <= frames_sent + CNT_WIDTH'(1);
                    if (!empty) begin
                        shift    <= head;
                        par_en_q <= par_en;
                        par_bit  <= (^head) ^ par_typ;
                        tx_out   <= 1'b0;
                        state    <= S_START;
                    end else begin
                        tx_out <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (!empty) begin
                                shift    <= head;
                                par_en_q <= par_en;
                                par_bit  <= (^head) ^ par_typ;
                                tx_out   <= 1'b0;
                                busy     <= 1'b1;
                                state    <= S_START;
                            end
                        end
                        S_START: begin
                            tx_out  <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= '0;
                            state   <= S_DATA;
                        end
                        S_DATA: begin
                            if (bit_cnt == BIT_LAST) begin
                                if (par_en_q) begin
                                    tx_out <= par_bit;
                                    state  <= S_PARITY;
                                end else begin
                                    tx_out   <= 1'b1;
                                    stop_cnt <= '0;
                                    state    <= S_STOP;
                                end
                            end else begin
                                tx_out  <= shift[0];
                                shift   <= shift >> 1;
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                        S_PARITY: begin
                            tx_out   <= 1'b1;
                            stop_cnt <= '0;
                            state    <= S_STOP;
                        end
                        S_STOP: begin
                            if (!stop_last) begin
                                stop_cnt <= stop_cnt + 1'b1;
                            end
`ifdef UART_FRAME_GAP_EN
                            else begin
                                gap_cnt <= '0;
                                state   <= S_GAP;
                            end
`endif
                        end
`ifdef UART_FRAME_GAP_EN
                        S_GAP: begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
`endif
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_seq_tx.sv
// Directed bench for uart_frame_seq_tx. Two instances share all inputs:
// dut_a uses one stop bit, dut_b uses two; sel picks which one is observed.
module tb_uart_frame_seq_tx;

`ifdef UART_FRAME_GAP_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bit_tick = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        par_en = 1'b0;
  logic        par_typ = 1'b0;
  logic        sel = 1'b0;

  logic        tx_a, busy_a, full_a, empty_a, ovf_a, done_a;
  logic [15:0] cnt_a;
  logic        tx_b, busy_b, full_b, empty_b, ovf_b, done_b;
  logic [15:0] cnt_b;

  logic        tx_out, busy, full, empty, overflow, frame_done;
  logic [15:0] frames_sent;

  int errors = 0;
  int checks = 0;
  int busy_ticks;
  int done_cnt;
  logic [0:0] exp_q[$];

  uart_frame_seq_tx #(.DATA_WIDTH(8), .DEPTH(8), .STOP_BITS(1), .CNT_WIDTH(16), .GAP_BITS(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .bit_tick(bit_tick), .wr_en(wr_en), .wr_data(wr_data),
    .par_en(par_en), .par_typ(par_typ), .tx_out(tx_a), .busy(busy_a), .full(full_a),
    .empty(empty_a), .overflow(ovf_a), .frame_done(done_a), .frames_sent(cnt_a)
  );

  uart_frame_seq_tx #(.DATA_WIDTH(8), .DEPTH(8), .STOP_BITS(2), .CNT_WIDTH(16), .GAP_BITS(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .bit_tick(bit_tick), .wr_en(wr_en), .wr_data(wr_data),
    .par_en(par_en), .par_typ(par_typ), .tx_out(tx_b), .busy(busy_b), .full(full_b),
    .empty(empty_b), .overflow(ovf_b), .frame_done(done_b), .frames_sent(cnt_b)
  );

  assign tx_out      = sel ? tx_b   : tx_a;
  assign busy        = sel ? busy_b : busy_a;
  assign full        = sel ? full_b : full_a;
  assign empty       = sel ? empty_b : empty_a;
  assign overflow    = sel ? ovf_b  : ovf_a;
  assign frame_done  = sel ? done_b : done_a;
  assign frames_sent = sel ? cnt_b  : cnt_a;

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic apply_reset();
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    bit_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // expected line bits, written in transmission order (leftmost first)
  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i]);
  endtask

  task automatic push_ones(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
  endtask

  // run n bit periods, one tick every 'period' clocks; compare the line after
  // each tick and confirm it holds steady on the clocks between ticks
  task automatic run_ticks(input int n, input int period);
    logic last_tx;
    logic [0:0] e;
    last_tx    = 1'b1;
    busy_ticks = 0;
    done_cnt   = 0;
    for (int i = 0; i < n; i++) begin
      for (int p = 1; p < period; p++) begin
        bit_tick = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("hold%0d_%0d", i, p), tx_out, last_tx);
      end
      bit_tick = 1'b1;
      @(posedge clk);
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
      check($sformatf("bit%0d", i), tx_out, e);
      if (busy) busy_ticks++;
      if (frame_done) done_cnt++;
      last_tx = tx_out;
    end
    bit_tick = 1'b0;
  endtask

  initial begin
    logic [7:0] d;

    apply_reset();
    check("rst_tx", tx_out, 1);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_ovf", overflow, 0);
    check("rst_done", frame_done, 0);
    check("rst_cnt", frames_sent, 0);

    // 0xAA, even parity; push lands on a tick cycle so the start bit waits a tick
    par_en   = 1'b1;
    par_typ  = 1'b0;
    wr_data  = 8'hAA;
    wr_en    = 1'b1;
    bit_tick = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    check("lat_tx", tx_out, 1);
    check("lat_busy", busy, 0);
    check("lat_empty", empty, 0);
    exp_q.delete();
    push_bits(32'b00101010101, 11);
    push_ones(GAP + 1);
    run_ticks(12 + GAP, 1);
    check("aa_busy_ticks", busy_ticks, 11 + GAP);
    check("aa_done", done_cnt, 1);
    check("aa_cnt", frames_sent, 1);
    check("aa_idle_busy", busy, 0);
    @(posedge clk);
    #1;
    check("aa_done_clear", frame_done, 0);

    // 0x05 then 0x03, odd parity, back to back
    apply_reset();
    par_en  = 1'b1;
    par_typ = 1'b1;
    push_byte(8'h05);
    push_byte(8'h03);
    exp_q.delete();
    push_bits(32'b01010000011, 11);
    push_ones(GAP);
    push_bits(32'b01100000011, 11);
    push_ones(GAP + 1);
    run_ticks(23 + 2 * GAP, 1);
    check("pair_busy_ticks", busy_ticks, 22 + 2 * GAP);
    check("pair_done", done_cnt, 2);
    check("pair_cnt", frames_sent, 2);
    check("pair_empty", empty, 1);

    // overflow: DEPTH+1 pushes while idle with no ticks
    apply_reset();
    par_en = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    check("ovf_full", full, 1);
    check("ovf_not_yet", overflow, 0);
    push_byte(8'hEE);
    check("ovf_set", overflow, 1);
    check("ovf_full2", full, 1);
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      d = 8'h10 + 8'(i);
      exp_q.push_back(1'b0);
      for (int b = 0; b < 8; b++) exp_q.push_back(d[b]);
      push_ones(1 + GAP);
    end
    push_ones(1);
    run_ticks(8 * (10 + GAP) + 1, 1);
    check("ovf_done", done_cnt, 8);
    check("ovf_cnt", frames_sent, 8);
    check("ovf_empty", empty, 1);
    check("ovf_busy", busy, 0);
    check("ovf_sticky", overflow, 1);

    // two stop bits, 0xCC, tick every 5th clock
    apply_reset();
    sel    = 1'b1;
    par_en = 1'b0;
    push_byte(8'hCC);
    exp_q.delete();
    push_bits(32'b00011001111, 11);
    push_ones(GAP + 1);
    run_ticks(12 + GAP, 5);
    check("cc_busy_ticks", busy_ticks, 11 + GAP);
    check("cc_done", done_cnt, 1);
    check("cc_cnt", frames_sent, 1);
    sel = 1'b0;

    // reset mid-frame after four data bits of 0x55
    apply_reset();
    par_en = 1'b0;
    push_byte(8'h55);
    exp_q.delete();
    push_bits(32'b01010, 5);
    run_ticks(5, 1);
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("mid_tx", tx_out, 1);
    check("mid_busy0", busy, 0);
    check("mid_empty", empty, 1);
    check("mid_cnt", frames_sent, 0);
    exp_q.delete();
    push_ones(4);
    run_ticks(4, 1);
    check("mid_after_busy", busy_ticks, 0);
    check("mid_after_done", done_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_seq_tx.md
Name: uart_frame_seq_tx

Overview:
- Parametrised UART frame sequencer. Buffers command bytes in an internal FIFO and serialises them back-to-back as UART frames on one bit line.
- Supports configurable data width, optional runtime parity, 1 or 2 stop bits, and a frames-sent counter.
- Sits between the system controller and the UART TX pin, driven by the divided bit clock domain.
- Replaces fixed-length hardwired bit-vector stimulus with arbitrary-length byte streams.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9).
- DEPTH, 8, FIFO entries; power of two, >=2.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- CNT_WIDTH, 16, width of frames_sent.
- GAP_BITS, 2, idle bits between frames; used only with UART_FRAME_GAP_EN.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- bit_tick  in  1  one-cycle bit-period strobe; line advances only when high.
- wr_en  in  1  push wr_data into FIFO.
- wr_data  in  DATA_WIDTH  byte to transmit.
- par_en  in  1  parity enable, sampled at frame start.
- par_typ  in  1  0 = even, 1 = odd, sampled at frame start.
- tx_out  out  1  serial line, idle high.
- busy  out  1  high from frame start until last stop/gap bit completes.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- overflow  out  1  sticky: push attempted while full.
- frame_done  out  1  one-cycle pulse when a frame's final bit period ends.
- frames_sent  out  CNT_WIDTH  completed-frame count, wraps.

Behaviour:
Reset:
- Synchronous reset, taken when reset_n is low at a posedge; overrides every other input, including reset mid-frame.
- After reset: tx_out=1, busy=0, full=0, empty=1, overflow=0, frame_done=0, frames_sent=0.
- FIFO pointers clear, FSM goes to IDLE, and the partially sent frame is discarded.

FIFO:
- Write pointer and read pointer plus a count; full when count==DEPTH.
- wr_en while full is ignored and sets overflow (cleared only by reset).
- A push and a pop in the same cycle are both honoured; count is unchanged, and when full the push is accepted.
- wr_data is visible to a pop one cycle after the push, never in the same cycle.

FSM (IDLE, START, DATA, PARITY, STOP, GAP). All transitions and tx_out updates occur only on cycles where bit_tick=1. Each state is held for exactly one tick per bit.
- IDLE, tick && !empty: pop head into shift register, latch par_en/par_typ, tx_out<=0, busy<=1, go to START.
- IDLE, tick && empty: tx_out stays 1.
- START: on tick, tx_out<=shift[0] (LSB first), bit counter<=0, go to DATA.
- DATA: on each tick shift right and drive the next bit. After DATA_WIDTH bits, go to PARITY if the latched par_en is set, else go to STOP and drive 1.
- PARITY: tx_out = XOR of data bits XOR par_typ, so the total count of ones including parity is even for par_typ=0 and odd for par_typ=1.
- STOP: drive 1 for STOP_BITS ticks.
- End of the final stop bit, with the gap feature disabled:
  - frame_done pulses and frames_sent increments.
  - If the FIFO is non-empty, pop the next byte and drive the start bit directly, with no idle bit between frames.
  - Otherwise busy<=0 and go to IDLE.
- Changing par_en/par_typ mid-frame has no effect until the next frame.
- Latency: a push into an empty, idle FIFO gives a start bit on the first tick at least one cycle after the push.
- Frame length in ticks: 1 + DATA_WIDTH + par_en + STOP_BITS.

Optional Feature:
Macro: UART_FRAME_GAP_EN
- Defined:
  - After the stop bits the FSM enters GAP, holding tx_out=1 and busy=1 for GAP_BITS ticks.
  - frame_done and the frames_sent increment occur at the end of GAP.
  - The next frame may start on the tick that ends GAP.
- Undefined: the GAP state and GAP_BITS logic are absent; frames run back-to-back as above.

Test Plan:
- Reset mid-frame (after 4 data bits of 0x55): assert reset_n=0 for one clk -> next cycle tx_out=1, busy=0, empty=1, frames_sent=0; line stays 1 on later ticks.
- Push 0xAA, par_en=1, par_typ=0, tick every cycle -> tx_out sequence 0,0,1,0,1,0,1,0,1,0,1; frame_done once; frames_sent=1.
- Push 0x05, then 0x03, par_en=1, par_typ=1 -> frames 0,10100000,1,1 and 0,11000000,1,1 with no idle bit between them (macro off); busy held for 22 ticks; frames_sent=2.
- Push DEPTH+1 bytes while bit_tick=0 -> full=1 after DEPTH pushes, overflow=1, last byte dropped; once ticking, exactly DEPTH frames are sent.
- par_en=0, STOP_BITS=2, byte 0xCC, bit_tick every 5th clk -> frame of 11 ticks (0,00110011,1,1); tx_out changes only on tick cycles.
- With UART_FRAME_GAP_EN, GAP_BITS=2: two bytes queued -> two idle-high ticks between the first stop bit and the second start bit; frame_done is delayed by 2 ticks.
